// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
//   Shared types and helpers for the fetch-stage program-counter unit.
//   - npc_sel_e : which source feeds the PC register on the next clock edge.
//   - sext_off  : sign-extends a branch word offset of run-time-constant width
//                 up to PC_MAX_W bits; callers keep the low ADDR_W bits.
// -----------------------------------------------------------------------------
package pc_pkg;

    // Widest PC the helper can extend into; ADDR_W must not exceed this.
    localparam int PC_MAX_W = 128;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,  // pc + 4
        NPC_BR   = 3'd1,  // pc + (sext(off) << 2)
        NPC_REG  = 3'd2,  // ext_pc (BR)
        NPC_RET  = 3'd3,  // RAS top, or ext_pc when the RAS is empty
        NPC_HOLD = 3'd4   // stall: keep pc
    } npc_sel_e;

    // Sign-extend the low 'w' bits of 'off' (w >= 1) to PC_MAX_W bits.
    function automatic logic [PC_MAX_W-1:0] sext_off(input logic [PC_MAX_W-1:0] off,
                                                     input int                  w);
        logic [PC_MAX_W-1:0] r;
        logic                sgn;
        sgn = off[w-1];
        for (int i = 0; i < PC_MAX_W; i++) begin
            r[i] = (i < w) ? off[i] : sgn;
        end
        return r;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack
//   Return-address stack as a circular buffer with a saturating entry count.
//   A push onto a full stack silently overwrites the oldest entry and sets the
//   sticky ovf flag. A pop on an empty stack is ignored. Push and pop in the
//   same cycle replace the current top in place (count unchanged).
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   push       in   write push_data as the new top
//   pop        in   discard the top (ignored when empty)
//   push_data  in   [ADDR_W]  value pushed
//   top        out  [ADDR_W]  current top-of-stack (meaningless when empty)
//   empty      out  no valid entries
//   full       out  RAS_DEPTH valid entries
//   ovf        out  sticky: a push overwrote the oldest entry
// -----------------------------------------------------------------------------
module ras_stack #(
    parameter int ADDR_W    = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;
    logic              ovf_q;

    logic              do_pop;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH_C);
    assign ovf    = ovf_q;
    assign top    = mem[top_ptr];
    assign do_pop = pop && !empty;

    // A combined push/pop rewrites the current top slot; a plain push writes
    // one slot above it. Because the depth is a power of two, the pointer wraps
    // naturally, which is what gives the overwrite-oldest behaviour when full.
    always_comb begin
        wr_en  = push;
        wr_idx = do_pop ? top_ptr : top_ptr + PTR_W'(1);
    end

    // Entry storage needs no reset: entries beyond count are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_ptr <= '0;
            count   <= '0;
            ovf_q   <= 1'b0;
        end else if (push && !do_pop) begin
            top_ptr <= top_ptr + PTR_W'(1);
            if (full) begin
                ovf_q <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (do_pop && !push) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// -----------------------------------------------------------------------------
// pc_ras_unit
//   Fetch-stage program counter with a return-address stack. The next PC is
//   chosen by priority (stall, pc_rd, ret, br_taken, sequential) and loaded on
//   the rising clock edge. BL pushes pc_out+4; RET pops the top, falling back
//   to ext_pc (with a one-cycle ras_unf pulse) when the stack is empty.
//   All PC arithmetic wraps modulo 2^ADDR_W.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low reset
//   stall       in   hold PC and RAS this cycle
//   br_taken    in   take the PC-relative branch
//   uncond_br   in   1: uncond_off, 0: cond_off
//   pc_rd       in   load PC from ext_pc
//   link        in   push pc_out+4 onto the RAS
//   ret         in   next PC from RAS top
//   cond_off    in   [COND_W]   signed word offset
//   uncond_off  in   [UNCOND_W] signed word offset
//   ext_pc      in   [ADDR_W]   register target / RET fallback
//   pc_out      out  [ADDR_W]   current PC
//   pc_4out     out  [ADDR_W]   pc_out + 4
//   ras_empty   out  RAS has no entries
//   ras_full    out  RAS has RAS_DEPTH entries
//   ras_ovf     out  sticky overwrite flag
//   ras_unf     out  pulse: previous cycle issued RET on an empty RAS
// -----------------------------------------------------------------------------
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                COND_W    = 19,
    parameter int                UNCOND_W  = 26,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                br_taken,
    input  logic                uncond_br,
    input  logic                pc_rd,
    input  logic                link,
    input  logic                ret,
    input  logic [COND_W-1:0]   cond_off,
    input  logic [UNCOND_W-1:0] uncond_off,
    input  logic [ADDR_W-1:0]   ext_pc,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [ADDR_W-1:0]   pc_4out,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_ovf,
    output logic                ras_unf
);

    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_4;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   br_target;
    logic [ADDR_W-1:0]   ras_top;
    logic                ras_unf_q;
    logic                unf_next;
    npc_sel_e            npc_sel;

    logic [PC_MAX_W-1:0] raw_off;
    logic [PC_MAX_W-1:0] ext_off;
    logic                unused_off_bits;

    assign pc_4    = pc_q + ADDR_W'(4);
    assign pc_out  = pc_q;
    assign pc_4out = pc_4;
    assign ras_unf = ras_unf_q;

    // Branch offset: pick the field, sign-extend, scale words to bytes.
    always_comb begin
        raw_off = '0;
        if (uncond_br) begin
            raw_off[UNCOND_W-1:0] = uncond_off;
        end else begin
            raw_off[COND_W-1:0] = cond_off;
        end
        ext_off = sext_off(raw_off, uncond_br ? UNCOND_W : COND_W);
    end

    // Bits above ADDR_W-2 fall off the end after the word-to-byte shift.
    assign unused_off_bits = ^ext_off[PC_MAX_W-1:ADDR_W-2];
    assign br_target       = pc_q + {ext_off[ADDR_W-3:0], 2'b00};

    // Next-PC source priority.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (stall) begin
            npc_sel = NPC_HOLD;
        end else if (pc_rd) begin
            npc_sel = NPC_REG;
        end else if (ret) begin
            npc_sel = NPC_RET;
        end else if (br_taken) begin
            npc_sel = NPC_BR;
        end
    end

    always_comb begin
        pc_next  = pc_4;
        unf_next = 1'b0;
        case (npc_sel)
            NPC_HOLD: pc_next = pc_q;
            NPC_REG:  pc_next = ext_pc;
            NPC_RET: begin
                if (ras_empty) begin
                    pc_next  = ext_pc;
                    unf_next = 1'b1;
                end else begin
                    pc_next  = ras_top;
                end
            end
            NPC_BR:   pc_next = br_target;
            default:  pc_next = pc_4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            ras_unf_q <= 1'b0;
        end else begin
            pc_q      <= pc_next;
            ras_unf_q <= unf_next;
        end
    end

    // Push happens for any BL that is not stalled, regardless of which next-PC
    // source wins. Pop only when RET actually selects the stack (pc_rd beats it).
    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (link && !stall),
        .pop       (ret && !stall && !pc_rd),
        .push_data (pc_4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf)
    );

endmodule
